softmax_rd_master: RTL and testbench



---
 rtl/softmax_rd_master_pkg.sv | 11 +
 rtl/softmax_fwft_fifo.sv | 73 +++++++
 rtl/softmax_rd_master.sv | 143 ++++++++++++++
 tb/tb_softmax_rd_master.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_rd_master_pkg.sv
// Shared constants for the softmax read master: FSM encoding and bus word geometry.
package softmax_rd_master_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam int BYTES_PER_WORD = 128 / 8;

endpackage

// File: rtl/softmax_fwft_fifo.sv
// Show-ahead FIFO: the head word sits in an output register, valid whenever not empty.
module softmax_fwft_fifo #(
   parameter int DW = 128,
   parameter int AW = 5
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic [DW-1:0] dout,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   used
);

   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

   logic [DW-1:0] mem_q [0:(2**AW)-1];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_next;
   logic [AW:0]   cnt_q, cnt_d;
   logic [DW-1:0] dout_q;
   logic          push_ok, pop_ok;

   assign pop_ok  = pop && (cnt_q != '0);
   assign push_ok = push && ((cnt_q != DEPTH) || pop_ok);
   assign rd_next = rd_ptr_q + 1'b1;

   always_comb begin
      cnt_d = cnt_q;
      if (push_ok && !pop_ok)
         cnt_d = cnt_q + 1'b1;
      else if (!push_ok && pop_ok)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         dout_q   <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (push_ok)
            wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)
            rd_ptr_q <= rd_next;
         // Refill the head register: a push into an empty (or emptying) FIFO bypasses memory.
         if (cnt_q == '0) begin
            if (push_ok)
               dout_q <= din;
         end else if (pop_ok) begin
            if (cnt_q == ONE)
               dout_q <= push_ok ? din : '0;
            else
               dout_q <= mem_q[rd_next];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem_q[wr_ptr_q] <= din;
   end

   assign dout  = dout_q;
   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == DEPTH);
   assign used  = cnt_q;

endmodule

// File: rtl/softmax_rd_master.sv
// Avalon-MM pipelined read master feeding the softmax load path through a show-ahead FIFO.
//   state | meaning
//   IDLE  | waiting for control_go
//   READ  | issuing reads while words remain and FIFO credit allows
//   DRAIN | all reads issued, waiting for responses and FIFO to empty
//   DONE  | transfer complete, control_done pulses on the following cycle
module softmax_rd_master
   import softmax_rd_master_pkg::*;
#(
   parameter int XAW        = 32,
   parameter int XDW        = BYTES_PER_WORD * 8,
   parameter int FIFO_DEPTH = 32,
   parameter int FIFO_AW    = 5
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             control_fixed_location,
   input  logic [XAW-1:0]   control_read_base,
   input  logic [XAW-1:0]   control_read_length,
   input  logic             control_go,
   output logic             control_done,
   input  logic             user_read_buffer,
   output logic [XDW-1:0]   user_buffer_data,
   output logic             user_data_available,
   output logic [XAW-1:0]   master_address,
   output logic             master_read,
   output logic [XDW/8-1:0] master_byteenable,
   input  logic [XDW-1:0]   master_readdata,
   input  logic             master_readdatavalid,
   input  logic             master_waitrequest
);

   localparam int BPW = XDW / 8;
   localparam int BSH = $clog2(BPW);
   localparam logic [XAW-1:0]     BPW_W   = XAW'(BPW);
   localparam logic [FIFO_AW+1:0] DEPTH_W = (FIFO_AW+2)'(FIFO_DEPTH);

   logic [1:0]         state_q, state_d;
   logic [XAW-1:0]     addr_q, addr_d;
   logic [XAW-1:0]     words_left_q, words_left_d;
   logic [FIFO_AW:0]   pending_q, pending_d;
   logic               fixed_q, fixed_d;
   logic               done_q, done_d;

   logic [XAW-1:0]     go_words;
   logic [FIFO_AW:0]   fifo_used;
   logic [FIFO_AW+1:0] credit_sum;
   logic               fifo_empty, unused_fifo_full;
   logic               accept, push;

   assign go_words   = control_read_length >> BSH;
   assign credit_sum = {1'b0, fifo_used} + {1'b0, pending_q};

   // Only registered terms feed master_read, and while stalled the credit sum can only
   // shrink (responses move words pending->used, pops remove them), so a request is never withdrawn.
   assign master_read = (state_q == ST_READ) && (words_left_q != '0) && (credit_sum < DEPTH_W);
   assign accept      = master_read && !master_waitrequest;
   // Responses with nothing outstanding are leftovers from before a reset.
   assign push        = master_readdatavalid && (pending_q != '0);

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      words_left_d = words_left_q;
      pending_d    = pending_q;
      fixed_d      = fixed_q;
      done_d       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (control_go) begin
               addr_d       = control_read_base;
               words_left_d = go_words;
               fixed_d      = control_fixed_location;
               state_d      = (go_words == '0) ? ST_DONE : ST_READ;
            end
         end
         ST_READ: begin
            if (accept) begin
               words_left_d = words_left_q - 1'b1;
               if (!fixed_q)
                  addr_d = addr_q + BPW_W;
            end
            if (words_left_q == '0)
               state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if ((pending_q == '0) && fifo_empty)
               state_d = ST_DONE;
         end
         ST_DONE: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      case ({accept, push})
         2'b10:   pending_d = pending_q + 1'b1;
         2'b01:   pending_d = pending_q - 1'b1;
         default: pending_d = pending_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         words_left_q <= '0;
         pending_q    <= '0;
         fixed_q      <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         words_left_q <= words_left_d;
         pending_q    <= pending_d;
         fixed_q      <= fixed_d;
         done_q       <= done_d;
      end
   end

   softmax_fwft_fifo #(
      .DW (XDW),
      .AW (FIFO_AW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (master_readdata),
      .pop   (user_read_buffer),
      .dout  (user_buffer_data),
      .empty (fifo_empty),
      .full  (unused_fifo_full),
      .used  (fifo_used)
   );

   assign user_data_available = !fifo_empty;
   assign master_address      = addr_q;
   assign master_byteenable   = '1;
   assign control_done        = done_q;

endmodule

// File: tb/tb_softmax_rd_master.sv
// Self-checking bench for softmax_rd_master: Avalon slave model plus data/address scoreboards.
module tb_softmax_rd_master;

   localparam int XAW   = 32;
   localparam int XDW   = 128;
   localparam int DEPTH = 32;
   localparam int AW    = 5;

   logic           clk = 1'b0;
   logic           rst;
   logic           control_fixed_location;
   logic [XAW-1:0] control_read_base;
   logic [XAW-1:0] control_read_length;
   logic           control_go;
   logic           control_done;
   logic           user_read_buffer;
   logic [XDW-1:0] user_buffer_data;
   logic           user_data_available;
   logic [XAW-1:0] master_address;
   logic           master_read;
   logic [XDW/8-1:0] master_byteenable;
   logic [XDW-1:0] master_readdata;
   logic           master_readdatavalid;
   logic           master_waitrequest;

   always #5 clk = ~clk;

   softmax_rd_master #(.XAW(XAW), .XDW(XDW), .FIFO_DEPTH(DEPTH), .FIFO_AW(AW)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .control_fixed_location (control_fixed_location),
      .control_read_base      (control_read_base),
      .control_read_length    (control_read_length),
      .control_go             (control_go),
      .control_done           (control_done),
      .user_read_buffer       (user_read_buffer),
      .user_buffer_data       (user_buffer_data),
      .user_data_available    (user_data_available),
      .master_address         (master_address),
      .master_read            (master_read),
      .master_byteenable      (master_byteenable),
      .master_readdata        (master_readdata),
      .master_readdatavalid   (master_readdatavalid),
      .master_waitrequest     (master_waitrequest)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] mk_data(input int seq, input logic [31:0] addr);
      return {seq[31:0], addr, ~addr, 16'h5AFE, seq[15:0]};
   endfunction

   // scoreboard / slave-model state
   logic [127:0] exp_q[$];
   logic [31:0]  exp_addr[$];
   logic [127:0] resp_data;
   int  used_m = 0, pend_m = 0;
   int  req_idx = 0, stall_idx = -1, stall_left = 0, pop_mode = 0;
   int  done_cnt = 0, pop_cnt = 0, word_seq = 0;
   int  done0 = 0, pop0 = 0;
   bit  resp_due = 0, stall_active = 0, stray = 0;

   // Slave and user agent: acts at the falling edge for the following rising edge.
   always @(negedge clk) begin
      bit acc, psh, pp;
      if (rst) begin
         master_readdatavalid = 1'b0;
         master_waitrequest   = 1'b0;
         user_read_buffer     = 1'b0;
         resp_due     = 0;
         stall_active = 0;
         used_m       = 0;
         pend_m       = 0;
         exp_q.delete();
         exp_addr.delete();
      end else begin
         if (control_done) begin
            done_cnt++;
            chk("done_drained", exp_q.size(), 0);
         end
         chk("avail", user_data_available, used_m != 0);

         psh = resp_due;
         master_readdatavalid = resp_due || stray;
         master_readdata      = resp_due ? resp_data : {4{32'hDEADBEEF}};
         stray    = 0;
         resp_due = 0;

         if (stall_left > 0 && req_idx == stall_idx && (master_read || stall_active)) begin
            chk("stall_read", master_read, 1);
            if (exp_addr.size() > 0)
               chk("stall_addr", master_address, exp_addr[0]);
            master_waitrequest = 1'b1;
            stall_left--;
            stall_active = 1;
         end else begin
            master_waitrequest = 1'b0;
            stall_active = 0;
         end

         case (pop_mode)
            0:       user_read_buffer = 1'b0;
            1:       user_read_buffer = 1'b1;
            default: user_read_buffer = 1'($urandom_range(0, 1));
         endcase

         if (master_read)
            chk("credit", (used_m + pend_m) < DEPTH, 1);
         acc = master_read && !master_waitrequest;
         pp  = user_read_buffer && (used_m != 0);

         if (pp) begin
            chk("data", user_buffer_data, exp_q.pop_front());
            pop_cnt++;
         end
         if (psh)
            chk("no_overflow", (used_m < DEPTH) || pp, 1);
         if (acc) begin
            chk("addr_expected", exp_addr.size() > 0, 1);
            if (exp_addr.size() > 0)
               chk("addr", master_address, exp_addr.pop_front());
            resp_data = mk_data(word_seq, master_address);
            exp_q.push_back(resp_data);
            word_seq++;
            resp_due = 1;
            pend_m++;
            req_idx++;
         end
         if (psh) begin
            used_m++;
            pend_m--;
         end
         if (pp)
            used_m--;
      end
   end

   task automatic xfer(input logic [31:0] base, input logic [31:0] len, input bit fixed);
      @(negedge clk); #1;
      for (int i = 0; i < int'(len / 16); i++)
         exp_addr.push_back(fixed ? base : base + 32'(i * 16));
      req_idx = 0;
      done0   = done_cnt;
      pop0    = pop_cnt;
      control_read_base      = base;
      control_read_length    = len;
      control_fixed_location = fixed;
      control_go             = 1'b1;
      @(negedge clk); #1;
      control_go = 1'b0;
      chk("first_read", master_read, len != 0);
   endtask

   task automatic wait_done(input string tag, input int maxcyc, input int words);
      int n = 0;
      while (done_cnt == done0 && n < maxcyc) begin
         @(negedge clk); #1;
         n++;
      end
      chk({tag, "_done_seen"}, done_cnt != done0, 1);
      chk({tag, "_words"}, pop_cnt - pop0, words);
      @(negedge clk); #1;
      chk({tag, "_done_1cyc"}, control_done, 0);
      chk({tag, "_done_once"}, done_cnt - done0, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      rst = 1'b1;
      control_go = 1'b0;
      control_fixed_location = 1'b0;
      control_read_base = '0;
      control_read_length = '0;
      user_read_buffer = 1'b0;
      master_readdata = '0;
      master_readdatavalid = 1'b0;
      master_waitrequest = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_done", control_done, 0);
      chk("rst_read", master_read, 0);
      chk("rst_addr", master_address, 0);
      chk("rst_avail", user_data_available, 0);
      chk("rst_bufdata", user_buffer_data, 0);
      chk("byteenable", master_byteenable, 16'hFFFF);
      #3 rst = 1'b0;

      // basic transfer
      pop_mode = 1;
      xfer(32'h1000, 64, 0);
      wait_done("basic", 200, 4);

      // waitrequest stall on the second read, random popping
      stall_idx  = 1;
      stall_left = 3;
      pop_mode   = 2;
      xfer(32'h1000, 64, 0);
      wait_done("stall", 200, 4);
      chk("stall_consumed", stall_left, 0);
      stall_idx = -1;

      // backpressure: no pops until the credit window fills
      pop_mode = 0;
      xfer(32'h4000, 1024, 0);
      n = 0;
      while (used_m < DEPTH && n < 300) begin
         @(negedge clk); #1;
         n++;
      end
      repeat (3) @(negedge clk);
      #1;
      chk("bp_read_low", master_read, 0);
      chk("bp_fifo_full", used_m + pend_m, DEPTH);
      chk("bp_avail", user_data_available, 1);
      pop_mode = 1;
      wait_done("bp", 1000, 64);

      // zero length: done two cycles after go, no reads
      xfer(32'h5000, 0, 0);
      chk("zero_done_early", control_done, 0);
      @(negedge clk); #1;
      chk("zero_done", control_done, 1);
      @(negedge clk); #1;
      chk("zero_done_off", control_done, 0);

      // fixed location
      xfer(32'h6000, 48, 1);
      wait_done("fixed", 200, 3);

      // go during READ is ignored; random popping gives simultaneous push/pop
      pop_mode = 2;
      xfer(32'h7000, 256, 0);
      @(negedge clk); #1;
      control_read_base   = 32'h9000;
      control_read_length = 64;
      control_go          = 1'b1;
      @(negedge clk); #1;
      control_go = 1'b0;
      wait_done("go_ignored", 400, 16);
      repeat (5) @(negedge clk);
      #1;
      chk("go_ignored_idle", master_read, 0);

      // reset mid-operation
      pop_mode = 1;
      xfer(32'h8000, 256, 0);
      n = 0;
      while ((pop_cnt - pop0) < 5 && n < 200) begin
         @(negedge clk); #1;
         n++;
      end
      chk("rst_mid_reached", (pop_cnt - pop0) >= 5, 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_read", master_read, 0);
      chk("rst_mid_addr", master_address, 0);
      chk("rst_mid_avail", user_data_available, 0);
      chk("rst_mid_bufdata", user_buffer_data, 0);
      chk("rst_mid_done", control_done, 0);
      @(negedge clk);
      #3 rst = 1'b0;
      stray = 1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_stray_dropped", user_data_available, 0);
      xfer(32'hA000, 32, 0);
      wait_done("after_rst", 200, 2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
